// File: rtl/uart_receive_controller.sv
// UART receiver: synchronizes the serial pin, deserializes LSB-first 8N1 frames on the
// shared oversampling tick, and hands bytes out on a valid/ready port with error flags.
module uart_receive_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 baud_tick,
    input  logic                 UART_RX_I,
    input  logic                 r_ready,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] r_data,
    output logic                 r_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [1:0] {S_RX_IDLE, S_RX_START, S_RX_DATA, S_RX_STOP} state_t;
    state_t state, state_nxt;

    logic                 rx_meta, rx_s, armed;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 half_hit, full_hit;
    logic                 sample_bit, stop_good, stop_bad, ovr_set;

    assign half_hit = baud_tick && (tick_cnt == TICK_HALF);
    assign full_hit = baud_tick && (tick_cnt == TICK_LAST);
    assign ovr_set  = stop_good && r_valid && !r_ready;

    // Idle-high synchronizer so reset does not look like a start edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= UART_RX_I;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= S_RX_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_RX_IDLE:  if (armed && !rx_s) state_nxt = S_RX_START;
            S_RX_START: if (half_hit) state_nxt = rx_s ? S_RX_IDLE : S_RX_DATA;
            S_RX_DATA:  if (full_hit && bit_cnt == BIT_LAST) state_nxt = S_RX_STOP;
            S_RX_STOP:  if (full_hit) state_nxt = S_RX_IDLE;
            default:    state_nxt = S_RX_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_RX_IDLE);
        sample_bit = (state == S_RX_DATA) && full_hit;
        stop_good  = (state == S_RX_STOP) && full_hit && rx_s;
        stop_bad   = (state == S_RX_STOP) && full_hit && !rx_s;
    end

    // Counters restart on every state change so each phase measures from its own entry.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            armed     <= 1'b0;
        end else begin
            if (state_nxt != state)  tick_cnt <= '0;
            else if (baud_tick)      tick_cnt <= tick_cnt + 1'b1;

            if (state_nxt != state)  bit_cnt <= '0;
            else if (sample_bit)     bit_cnt <= bit_cnt + 1'b1;

            if (sample_bit) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};

            // A line that ends a frame low must go high again before the next start.
            if (state == S_RX_STOP && full_hit) armed <= 1'b0;
            else if (state == S_RX_IDLE && rx_s) armed <= 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (stop_good && (!r_valid || r_ready)) begin
            r_data  <= shift_reg;
            r_valid <= 1'b1;
        end else if (r_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= stop_bad;
            if (ovr_set)      overrun <= 1'b1;
            else if (err_clr) overrun <= 1'b0;
        end
    end

endmodule
